// File: rtl/dffram_pkg.sv
// Shared types and helpers for the parametrised 1RW/1R flip-flop RAM.
// byte_merge is sized for the widest supported word; callers cast to their width.
package dffram_pkg;

  localparam int unsigned MAX_COLS = 16;
  localparam int unsigned MAX_DW   = 8 * MAX_COLS;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Replace the byte lanes of old_word selected by we with those of new_word
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]   old_word,
                                                   input logic [MAX_DW-1:0]   new_word,
                                                   input logic [MAX_COLS-1:0] we);
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_COLS; i++) begin
      if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dffram_1rw1r_if.sv
// Port bundle for dffram_1rw1r: clear control, RW port 0 and read-only port 1.
interface dffram_1rw1r_if #(
  parameter int unsigned A_WIDTH = 7,
  parameter int unsigned COLS    = 4
);
  localparam int unsigned DW = 8 * COLS;

  logic               CLR;
  logic               BUSY;
  logic               EN0;
  logic [COLS-1:0]    WE0;
  logic [A_WIDTH-1:0] A0;
  logic [DW-1:0]      Di0;
  logic [DW-1:0]      Do0;
  logic               EN1;
  logic [A_WIDTH-1:0] A1;
  logic [DW-1:0]      Do1;

  modport master (
    output CLR, EN0, WE0, A0, Di0, EN1, A1,
    input  BUSY, Do0, Do1
  );

  modport slave (
    input  CLR, EN0, WE0, A0, Di0, EN1, A1,
    output BUSY, Do0, Do1
  );

endinterface

// File: rtl/dffram_clear_ctl.sv
// Clear engine: walks every address once, writing zero, after reset or on a CLR pulse.
// BUSY is a direct decode of the one-bit state register.
module dffram_clear_ctl
  import dffram_pkg::*;
#(
  parameter int unsigned A_WIDTH        = 7,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               busy,
  output logic               clr_we,
  output logic [A_WIDTH-1:0] clr_addr
);

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_e             state, state_nx;
  logic [A_WIDTH-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // CLR is only honoured in IDLE; the last address returns to IDLE and the counter wraps to 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clr) state_nx = CLEAR;
      end
      CLEAR: begin
        cnt_nx = A_WIDTH'(cnt + 1'b1);
        if (cnt == '1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/dffram_1rw1r.sv
// Flip-flop RAM with one byte-writable RW port, one read-only port, optional output
// register and a built-in zeroing engine. Port 1 sees port-0 writes to the same address.
module dffram_1rw1r
  import dffram_pkg::*;
#(
  parameter int unsigned A_WIDTH        = 7,
  parameter int unsigned COLS           = 4,
  parameter int unsigned REG_OUT        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic           CLK,
  input logic           RST_N,
  dffram_1rw1r_if.slave bus
);

  localparam int unsigned DW        = 8 * COLS;
  localparam int unsigned NUM_WORDS = 1 << A_WIDTH;

  function automatic logic [DW-1:0] merge_w(input logic [DW-1:0]   old_word,
                                            input logic [DW-1:0]   new_word,
                                            input logic [COLS-1:0] we);
    return DW'(byte_merge(MAX_DW'(old_word), MAX_DW'(new_word), MAX_COLS'(we)));
  endfunction

  logic               busy;
  logic               clr_we;
  logic [A_WIDTH-1:0] clr_addr;

  dffram_clear_ctl #(
    .A_WIDTH        (A_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctl (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (bus.CLR),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.BUSY = busy;

  logic [DW-1:0] mem [NUM_WORDS];

  logic          en0_c, en1_c, fwd_c;
  logic [DW-1:0] rd0_c, wr0_c, rd1_c;

  // Port enables are gated off for the whole clear
  assign en0_c = bus.EN0 & ~busy;
  assign en1_c = bus.EN1 & ~busy;
  assign rd0_c = mem[bus.A0];
  assign wr0_c = merge_w(rd0_c, bus.Di0, bus.WE0);
  assign fwd_c = en0_c && (bus.WE0 != '0) && (bus.A0 == bus.A1);
  assign rd1_c = fwd_c ? wr0_c : mem[bus.A1];

  // Array contents survive reset; only the clear engine or port 0 change them
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (en0_c) begin
      mem[bus.A0] <= wr0_c;
    end
  end

  logic [DW-1:0] d0_s1, d1_s1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d0_s1 <= '0;
      d1_s1 <= '0;
    end else begin
      d0_s1 <= en0_c ? rd0_c : '0;
      d1_s1 <= en1_c ? rd1_c : '0;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DW-1:0] d0_s2, d1_s2;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          d0_s2 <= '0;
          d1_s2 <= '0;
        end else begin
          d0_s2 <= d0_s1;
          d1_s2 <= d1_s1;
        end
      end

      assign bus.Do0 = d0_s2;
      assign bus.Do1 = d1_s2;
    end else begin : g_direct_out
      assign bus.Do0 = d0_s1;
      assign bus.Do1 = d1_s1;
    end
  endgenerate

endmodule
